// File: rtl/mbmul_seq.sv
// Iterative radix-4 modified-Booth multiplier: DPC Booth digits per clock,
// valid/ready on both sides, synchronous abort via clear_i.
module mbmul_seq #(
  parameter int unsigned M_DW = 8,
  parameter int unsigned N_DW = 8,
  parameter int unsigned DPC  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [M_DW-1:0]        m_i,
  input  logic [N_DW-1:0]        n_i,
  input  logic                   signed_i,
  input  logic                   clear_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [M_DW+N_DW-1:0]   p_o,
  output logic                   busy_o
);

  localparam int unsigned C_DW = M_DW + N_DW;
  localparam int unsigned ND   = N_DW / 2 + 1;
  localparam int unsigned ITER = (ND + DPC - 1) / DPC;
  localparam int unsigned AW   = C_DW + 3;
  localparam int unsigned NB   = 2 * ITER * DPC + 1;
  localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   mm_q, mm_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [NB-1:0]   nn_q, nn_d;
  logic [C_DW-1:0] p_q, p_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [AW-1:0]   acc_sum_c;
  logic [M_DW:0]   m_ext_c;
  logic [NB-1:0]   n_ext_c;
  logic            last_c;

  assign last_c      = (cnt_q == CW'(ITER - 1));
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign p_o         = p_q;

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mm_q        <= '0;
      acc_q       <= '0;
      nn_q        <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mm_q        <= mm_d;
      acc_q       <= acc_d;
      nn_q        <= nn_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next state; clear_i overrides both handshakes
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (in_valid_i)  state_d = S_CALC;
        S_CALC:  if (last_c)      state_d = S_DONE;
        S_DONE:  if (out_ready_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Booth digit recoding and accumulation of DPC partial products
  always_comb begin
    logic [2:0]    dig;
    logic [AW-1:0] pp;
    acc_sum_c = acc_q;
    for (int j = 0; j < int'(DPC); j++) begin
      dig = nn_q[2*j +: 3];
      pp  = '0;
      if ((dig == 3'b011) || (dig == 3'b100)) begin
        pp = mm_q << (2*j + 1);
      end else if (dig[1] ^ dig[0]) begin
        pp = mm_q << (2*j);
      end
      if (dig[2] && !(dig[1] && dig[0])) begin
        pp = (~pp) + 1'b1;
      end
      acc_sum_c = acc_sum_c + pp;
    end
  end

  // Datapath and registered outputs
  always_comb begin
    cnt_d   = cnt_q;
    mm_d    = mm_q;
    acc_d   = acc_q;
    nn_d    = nn_q;
    p_d     = p_q;
    m_ext_c = {signed_i & m_i[M_DW-1], m_i};
    n_ext_c = {{(NB-N_DW-1){signed_i & n_i[N_DW-1]}}, n_i, 1'b0};
    case (state_q)
      S_IDLE: begin
        if (in_valid_i && !clear_i) begin
          mm_d  = {{(AW-M_DW-1){m_ext_c[M_DW]}}, m_ext_c};
          nn_d  = n_ext_c;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      S_CALC: begin
        // multiplicand moves up and multiplier down, so digit j always sits at bit 2j
        acc_d = acc_sum_c;
        mm_d  = mm_q << (2*DPC);
        nn_d  = {{(2*DPC){nn_q[NB-1]}}, nn_q[NB-1:2*DPC]};
        cnt_d = cnt_q + 1'b1;
        if (last_c) p_d = acc_sum_c[C_DW-1:0];
      end
      default: ;
    endcase
    if (clear_i) p_d = '0;
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_mbmul_seq.sv
// Bench for mbmul_seq: four configurations driven in lockstep and checked
// every cycle against an arithmetic reference with a latency/handshake model.
module tb_mbmul_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, sgn = 1'b0, clr = 1'b0, out_ready = 1'b1;
  logic [7:0] m = '0, n = '0;
  logic [8:0] m3 = '0;
  logic [6:0] n3 = '0;
  logic [3:0] in_ready, out_valid, busy;
  logic [3:0][15:0] p;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mbmul_seq #(.M_DW(8), .N_DW(8), .DPC(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
    .m_i(m), .n_i(n), .signed_i(sgn), .clear_i(clr), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready), .p_o(p[0]), .busy_o(busy[0]));

  mbmul_seq #(.M_DW(8), .N_DW(8), .DPC(2)) u_d2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
    .m_i(m), .n_i(n), .signed_i(sgn), .clear_i(clr), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready), .p_o(p[1]), .busy_o(busy[1]));

  mbmul_seq #(.M_DW(8), .N_DW(8), .DPC(5)) u_d5 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready[2]),
    .m_i(m), .n_i(n), .signed_i(sgn), .clear_i(clr), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready), .p_o(p[2]), .busy_o(busy[2]));

  mbmul_seq #(.M_DW(9), .N_DW(7), .DPC(1)) u_9x7 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready[3]),
    .m_i(m3), .n_i(n3), .signed_i(sgn), .clear_i(clr), .out_valid_o(out_valid[3]),
    .out_ready_i(out_ready), .p_o(p[3]), .busy_o(busy[3]));

  // Compute cycles per instance: ceil((N/2+1)/DPC)
  function automatic int lat_of(input int i);
    case (i)
      0:       return 5;
      1:       return 3;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input int aw, input int bw);
    longint x, y;
    x = 0;
    y = 0;
    for (int k = 0; k < aw; k++) if (a[k]) x += (64'sd1 << k);
    for (int k = 0; k < bw; k++) if (b[k]) y += (64'sd1 << k);
    if (s && a[aw-1]) x -= (64'sd1 << aw);
    if (s && b[bw-1]) y -= (64'sd1 << bw);
    return 16'(x * y);
  endfunction

  task automatic check(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] @%0t: got %h expected %h", nm, i, $time, act, exp);
    end
  endtask

  // Reference: 0 idle, 1 computing, 2 holding result
  int          mst  [4] = '{0, 0, 0, 0};
  int          mcnt [4] = '{0, 0, 0, 0};
  logic [15:0] mexp [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  bit          pzero[4] = '{1'b1, 1'b1, 1'b1, 1'b1};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || clr) begin
        mst[i]   <= 0;
        pzero[i] <= 1'b1;
      end else begin
        case (mst[i])
          0: if (in_valid) begin
            mst[i]  <= 1;
            mcnt[i] <= lat_of(i);
            mexp[i] <= (i == 3) ? ref_mul(16'(m3), 16'(n3), sgn, 9, 7)
                                : ref_mul(16'(m), 16'(n), sgn, 8, 8);
          end
          1: begin
            if (mcnt[i] == 1) begin
              mst[i]   <= 2;
              pzero[i] <= 1'b0;
            end
            mcnt[i] <= mcnt[i] - 1;
          end
          default: if (out_ready) mst[i] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        check("in_ready", i, 16'(in_ready[i]), 16'(mst[i] == 0));
        check("out_valid", i, 16'(out_valid[i]), 16'(mst[i] == 2));
        check("busy", i, 16'(busy[i]), 16'(mst[i] != 0));
        if (mst[i] == 2) check("product", i, p[i], mexp[i]);
        if (pzero[i]) check("p_zero", i, p[i], 16'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    for (int i = 0; i < 4; i++) begin
      check({nm, "_in_ready"}, i, 16'(in_ready[i]), 16'h1);
      check({nm, "_out_valid"}, i, 16'(out_valid[i]), 16'h0);
      check({nm, "_busy"}, i, 16'(busy[i]), 16'h0);
      check({nm, "_p"}, i, p[i], 16'h0);
    end
  endtask

  task automatic drive_random();
    m   = 8'($urandom);
    n   = 8'($urandom);
    m3  = 9'($urandom);
    n3  = 7'($urandom);
    sgn = 1'($urandom);
  endtask

  // One operation with out_ready high; checks latency and optional literal products
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [8:0] a3, input logic [6:0] b3,
                       input logic [15:0] lit, input logic [15:0] lit3, input bit use_lit);
    int lat[4];
    lat = '{-1, -1, -1, -1};
    out_ready = 1'b1;
    m = a; n = b; sgn = s; m3 = a3; n3 = b3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drive_random();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && lat[i] < 0) begin
          lat[i] = k;
          if (use_lit) check("p_literal", i, p[i], (i == 3) ? lit3 : lit);
        end
      end
    end
    for (int i = 0; i < 4; i++) check("latency", i, 16'(lat[i]), 16'(lat_of(i)));
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    do_op(8'd255, 8'd255, 1'b0, 9'd511, 7'd127, 16'hFE01, 16'hFD81, 1'b1);
    do_op(8'h80, 8'h80, 1'b1, 9'h100, 7'h40, 16'h4000, 16'h4000, 1'b1);
    do_op(8'h80, 8'h7F, 1'b1, 9'd1, 7'h7F, 16'hC080, 16'hFFFF, 1'b1);
    do_op(8'h01, 8'hFF, 1'b1, 9'h1FF, 7'h3F, 16'hFFFF, 16'hFFC1, 1'b1);
    do_op(8'd200, 8'd3, 1'b0, 9'd300, 7'd100, 16'h0258, 16'h7530, 1'b1);

    // Backpressure: result held for 10 cycles, then a single ready pulse
    out_ready = 1'b0;
    m = 8'd255; n = 8'd255; sgn = 1'b0; m3 = 9'd511; n3 = 7'd127;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drive_random();
    repeat (5) tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        check("hold_valid", i, 16'(out_valid[i]), 16'h1);
        check("hold_in_ready", i, 16'(in_ready[i]), 16'h0);
        check("hold_p", i, p[i], (i == 3) ? 16'hFD81 : 16'hFE01);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("release_in_ready", i, 16'(in_ready[i]), 16'h1);
      check("release_valid", i, 16'(out_valid[i]), 16'h0);
    end
    tick();
    out_ready = 1'b1;

    // Abort in the second compute cycle, then a fresh operation
    m = 8'd50; n = 8'd60; sgn = 1'b0; m3 = 9'd70; n3 = 7'd80;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_idle("clear_calc");
    for (int k = 0; k < 6; k++) begin
      tick();
      for (int i = 0; i < 4; i++) check("stale_valid", i, 16'(out_valid[i]), 16'h0);
    end
    do_op(8'd12, 8'hFD, 1'b1, 9'd12, 7'h7D, 16'hFFDC, 16'hFFDC, 1'b1);

    // clear_i coincident with out_ready_i while holding a result
    out_ready = 1'b0;
    m = 8'd9; n = 8'd10; sgn = 1'b0; m3 = 9'd11; n3 = 7'd12;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    clr = 1'b1;
    out_ready = 1'b1;
    tick();
    clr = 1'b0;
    check_idle("clear_done");
    repeat (3) tick();

    // Asynchronous reset mid-computation
    m = 8'd33; n = 8'd44; sgn = 1'b0; m3 = 9'd55; n3 = 7'd66;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1 check_idle("async_reset");
    tick();
    rst = 1'b0;
    tick();
    do_op(8'd7, 8'd9, 1'b0, 9'd7, 7'd9, 16'h003F, 16'h003F, 1'b1);

    // Randomised single operations with latency checks
    for (int k = 0; k < 30; k++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 9'($urandom), 7'($urandom),
            16'h0, 16'h0, 1'b0);
    end

    // Free-running random traffic with backpressure and occasional aborts
    for (int k = 0; k < 400; k++) begin
      drive_random();
      in_valid  = ($urandom_range(0, 2) == 0);
      out_ready = 1'($urandom);
      clr       = ($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid = 1'b0;
    clr = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mbmul_seq.md
Name: mbmul_seq

Overview:
Iterative radix-4 modified-Booth multiplier. It retires DPC Booth digits per clock and accumulates the partial products into a full-width product. It supports signed and unsigned operands, uses valid/ready handshakes on input and output, and has a synchronous abort. It is the sequential, area-lean counterpart to the combinational partial-product codecs, and sits in the datapath where a multi-cycle multiply is acceptable.

Parameters:
M_DW, 8, multiplicand width (>=2)
N_DW, 8, multiplier width (>=2)
DPC, 1, Booth digits processed per cycle (1..ND)
C_DW (localparam), M_DW+N_DW, product width
ND (localparam), N_DW/2+1 (integer division), Booth digit count
ITER (localparam), ceil(ND/DPC), compute cycles per operation

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
in_valid_i  input  1  operand valid
in_ready_o  output  1  block can accept operands
m_i  input  M_DW  multiplicand
n_i  input  N_DW  multiplier
signed_i  input  1  1 = both operands two's complement, 0 = both unsigned
clear_i  input  1  synchronous abort, drops any operation in flight
out_valid_o  output  1  product valid
out_ready_i  input  1  consumer accepts product
p_o  output  C_DW  product
busy_o  output  1  high in CALC or DONE

Behaviour:
- Reset (rst_i high, asynchronous): state=IDLE, in_ready_o=1, out_valid_o=0, busy_o=0, p_o=0. Internal counter and accumulator are cleared.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC when in_valid_i & in_ready_o. On this edge, latch m_i, n_i, and signed_i, clear the accumulator, and load the digit counter with 0.
  - CALC -> DONE after exactly ITER cycles in CALC.
  - DONE -> IDLE on the edge where out_valid_o & out_ready_i.
- in_ready_o = (state==IDLE). There is no accept while CALC or DONE.
- Operand extension:
  - The multiplicand is extended to M_DW+1 bits: sign-extended when signed_i=1, zero-extended otherwise.
  - The multiplier is extended to 2*ND bits the same way, with an implicit 0 at bit -1.
  - Digits beyond ND, up to ITER*DPC, are further sign/zero extension and contribute 0.
- Per CALC cycle: encode DPC digits (neg/one/two), form DPC partial products in (-2M..2M), and add them to the accumulator at their weights 4^k. The accumulator width is C_DW+3; the add is exact.
- Result: the exact product modulo 2^C_DW. The product always fits for both modes, so it is exact.
- out_valid_o=1 only in DONE. p_o is stable while out_valid_o=1 and out_ready_i=0.
- Latency: an operation accepted on edge t has out_valid_o high after edge t+ITER. Minimum initiation interval is ITER+2 cycles.
- clear_i high on any edge forces IDLE, out_valid_o=0, p_o=0, and discards the result. clear_i has priority over the input handshake and the output handshake in the same cycle.
- A reset mid-CALC or in DONE aborts immediately with no output. The next accept behaves as the first after reset.
- signed_i, m_i, and n_i are ignored outside the accept cycle.

Test Plan:
1. M_DW=N_DW=8, DPC=1, signed_i=0, m=255, n=255 -> p_o=16'hFE01. out_valid_o rises 5 cycles after the accept edge.
2. Signed mode with m=-128, n=-128 -> 16'h4000. m=-128, n=127 -> 16'hC080. m=1, n=-1 -> 16'hFFFF.
3. DPC=2, 8x8, unsigned m=200, n=3 -> 16'h0258 after 3 cycles. N_DW=7, M_DW=9, DPC=1, signed m=-256, n=-64 -> 16'h4000 after 4 cycles.
4. Backpressure: hold out_ready_i=0 for 10 cycles in DONE -> p_o and out_valid_o stay constant and in_ready_o=0 throughout. A single out_ready_i pulse -> IDLE next cycle.
5. clear_i in the 2nd CALC cycle, then a new accept of 12*(-3) signed -> no stale result, and p_o=16'hFFDC. clear_i together with out_ready_i in DONE -> IDLE with no double handshake.
6. rst_i asserted asynchronously mid-cycle during CALC -> outputs go to reset values before the next clock edge. After release, 7*9 unsigned -> 16'h003F. Randomised signed/unsigned cross-check against a reference model for DPC in {1,2,ND}.
